// File: rtl/monitor_pkg.sv
// monitor_pkg: verdict/classification types and the store classifier shared by store_monitor
package monitor_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, PASS = 2'd1, FAIL = 2'd2, TIMEOUT = 2'd3} state_t;
  typedef enum logic [1:0] {ST_NONE, ST_PASS, ST_FAIL, ST_SCRATCH} store_cls_t;
  function automatic store_cls_t classify(input logic mw, input logic [31:0] adr, input logic [31:0] data,
                                          input logic [31:0] pass_adr, input logic [31:0] pass_data,
                                          input logic [31:0] scratch_adr);
    return !mw ? ST_NONE : adr == pass_adr ? (data == pass_data ? ST_PASS : ST_FAIL) :
           adr == scratch_adr ? ST_SCRATCH : ST_FAIL;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter (clk, rst_n async low, clr sync, en) saturating at all-ones, output q
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = clr ? '0 : (en && !(&q_q)) ? q_q + 1'b1 : q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/store_monitor.sv
// store_monitor: classifies committed stores into a sticky RUN/PASS/FAIL/TIMEOUT verdict with halt, counters and last-store capture
module store_monitor
  import monitor_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             MemWrite,
  input  logic [31:0]      DataAdr,
  input  logic [31:0]      WriteData,
  output logic [1:0]       state,
  output logic             done,
  output logic             halt,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      last_adr,
  output logic [31:0]      last_data
);
  state_t      state_q, state_d;
  logic [31:0] last_adr_q, last_adr_d, last_data_q, last_data_d;
  store_cls_t  cls;
  logic        run, acc, tmo;
  always_comb begin
    run         = state_q == RUN;
    acc         = run && MemWrite;
    cls         = classify(MemWrite, DataAdr, WriteData, PASS_ADDR, PASS_DATA, SCRATCH_ADDR);
    tmo         = run && cycle_count == CNT_W'(TIMEOUT_CYCLES - 1);
    state_d     = clear ? RUN : !run ? state_q : cls == ST_PASS ? PASS : cls == ST_FAIL ? FAIL :
                  tmo ? TIMEOUT : RUN;
    last_adr_d  = clear ? '0 : acc ? DataAdr : last_adr_q;
    last_data_d = clear ? '0 : acc ? WriteData : last_data_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= RUN;
      last_adr_q  <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      last_adr_q  <= last_adr_d;
      last_data_q <= last_data_d;
    end
  sat_counter #(.W(CNT_W)) u_store_cnt (
    .clk(clk), .rst_n(reset), .clr(clear), .en(acc), .q(store_count)
  );
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst_n(reset), .clr(clear), .en(run), .q(cycle_count)
  );
  assign state     = state_q;
  assign done      = !run;
  assign halt      = !run;
  assign last_adr  = last_adr_q;
  assign last_data = last_data_q;
endmodule

// File: doc/store_monitor.md
# store_monitor

Synthesizable end-of-test monitor that sits directly downstream of the single-cycle RISC-V core's data-memory store bus (`MemWrite`, `DataAdr`, `WriteData`). It watches every committed store and classifies the run as PASS, FAIL or TIMEOUT. It freezes a verdict plus diagnostic captures, so FPGA builds and benches read one status word instead of decoding stores themselves. It also drives `halt` so the core can be stopped on a verdict.

## Interface
Parameters:
- `PASS_ADDR`, 32'd100: store address that signals test completion.
- `PASS_DATA`, 32'd25: data required at `PASS_ADDR` for PASS.
- `SCRATCH_ADDR`, 32'd96: store address that is always legal and has no effect on the verdict.
- `TIMEOUT_CYCLES`, 1000: cycles in RUN before TIMEOUT. Legal range is 1 to 2^CNT_W−1.
- `CNT_W`, 16: width of the cycle and store counters.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous restart to RUN. Has the same effect as reset, without the async path.
- `MemWrite`  in  1: store strobe from the core.
- `DataAdr`  in  32: store byte address.
- `WriteData`  in  32: store data.
- `state`  out  2: verdict. 0=RUN, 1=PASS, 2=FAIL, 3=TIMEOUT.
- `done`  out  1: high when `state` != RUN.
- `halt`  out  1: equal to `done`. Intended for the core's clock-enable or PC-hold.
- `store_count`  out  CNT_W: number of stores accepted in RUN. Saturates at all-ones.
- `cycle_count`  out  CNT_W: number of cycles spent in RUN.
- `last_adr`, `last_data`  out  32 each: address and data of the most recent store accepted in RUN.

## Operation
- FSM states: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and sticky until `reset` is low or `clear` is high.
- A store is accepted on a rising edge where `MemWrite`=1 and `state`=RUN.
- Classification of an accepted store, evaluated in this priority order:
  1. `DataAdr`==PASS_ADDR and `WriteData`==PASS_DATA → PASS.
  2. `DataAdr`==PASS_ADDR and `WriteData` differs → FAIL.
  3. `DataAdr`==SCRATCH_ADDR → stay in RUN.
  4. Any other address → FAIL.
- Every accepted store updates `last_adr`/`last_data` and increments `store_count` (saturating), including the store that causes PASS or FAIL.
- `cycle_count` increments on every RUN cycle. It freezes when a terminal state is entered.
- Timeout: on an edge in RUN where `cycle_count`==TIMEOUT_CYCLES−1 and no PASS/FAIL condition is present → TIMEOUT.
- Simultaneous store verdict and timeout on the same edge: the store verdict (PASS or FAIL) wins.
- Stores arriving while in a terminal state are ignored. No output changes.
- `clear` high: on that edge, force the same values as reset. `clear` has priority over every other event on that edge.

## Timing
- Reset values: `state`=RUN, `done`=0, `halt`=0, all counters 0, `last_adr`=0, `last_data`=0.
- All outputs are registered. A store sampled at edge N is visible on the outputs after edge N. `done`/`halt` rise in the same cycle `state` leaves RUN. No combinational input-to-output path.
- Latency from the PASS store to `done`=1 is one edge.
- TIMEOUT is entered on the TIMEOUT_CYCLES-th edge after reset release. At that point `cycle_count` = TIMEOUT_CYCLES.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronous). Counting resumes on the first edge after release.
- `store_count` at all-ones: holds at all-ones. The verdict is unaffected.

## Structure
- Package `monitor_pkg`: `state_t` enum (RUN=2'd0, PASS=2'd1, FAIL=2'd2, TIMEOUT=2'd3) and the store-classification enum.
- One sub-module, `sat_counter`: parameterized width, enable, synchronous clear, async active-low reset. Instantiated for `store_count` (saturating). `cycle_count` reuses it, since its maximum value is bounded by TIMEOUT_CYCLES.
- The top-level `store_monitor` holds the FSM, the classifier and the capture registers.

## Test plan
- Reset 22 ns. Stores (96, 7), (96, 9), then (100, 25) → `state`=PASS, `store_count`=3, `last_adr`=100, `last_data`=25, `halt`=1 one edge after the PASS store.
- Store (100, 24) → FAIL. A following store (100, 25) → ignored, state stays FAIL, `store_count` stays 1.
- Store (104, 0) → FAIL, `last_adr`=104.
- No stores, TIMEOUT_CYCLES=20 → TIMEOUT after the 20th edge, `cycle_count`=20, then frozen.
- TIMEOUT_CYCLES=20 with (100, 25) presented on the 20th edge → PASS, not TIMEOUT.
- Reset pulsed low mid-RUN with `store_count`=2 → outputs zero immediately. `clear` in PASS → RUN, counters 0 on the next edge.
